// File: rtl/char_pkg.sv
// Shared encodings for the character sprite engine: command/facing codes,
// sprite-sheet facing index mapping and draw sequencer states.
package char_pkg;

    typedef enum logic [2:0] {
        DIR_NONE   = 3'd0,
        DIR_ATTACK = 3'd1,
        DIR_UP     = 3'd2,
        DIR_DOWN   = 3'd3,
        DIR_LEFT   = 3'd4,
        DIR_RIGHT  = 3'd5
    } dir_e;

    typedef enum logic [2:0] {
        DS_IDLE     = 3'd0,
        DS_RUN      = 3'd1,
        DS_FLUSH    = 3'd2,
        DS_DONE     = 3'd3,
        DS_WAIT_LOW = 3'd4
    } draw_state_e;

    // Sprite sheet rows of poses are ordered down, left, up, right.
    function automatic logic [1:0] facing_idx(input dir_e d);
        case (d)
            DIR_LEFT:  return 2'd1;
            DIR_UP:    return 2'd2;
            DIR_RIGHT: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

    function automatic logic is_move(input dir_e d);
        return (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_RIGHT);
    endfunction

endpackage

// File: rtl/sprite_draw_seq.sv
// Sprite draw sequencer: walks the sprite rectangle one ROM address per cycle
// and emits pixel coordinates aligned with the one-cycle ROM read latency.
module sprite_draw_seq
    import char_pkg::*;
#(
    parameter int          SPRITE_W    = 16,
    parameter int          SPRITE_H    = 16,
    parameter int          COL_W       = 8,
    parameter int          ROW_W       = 4,
    parameter logic [5:0]  TRANSPARENT = 6'h3F,
    localparam int         PXW         = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   draw,
    input  logic                   abort,
    input  logic [8:0]             x_pos,
    input  logic [7:0]             y_pos,
    input  logic [COL_W-1:0]       col_base,
    output logic [ROW_W+COL_W-1:0] mem_addr,
    input  logic [5:0]             mem_q,
    output logic [8:0]             x_draw,
    output logic [7:0]             y_draw,
    output logic [5:0]             colour,
    output logic                   vga_write,
    output logic                   draw_done
);

    draw_state_e      state_q, state_d;
    logic [PXW-1:0]   px_q, px_d;
    logic [ROW_W-1:0] py_q, py_d;
    logic [8:0]       base_x_q, base_x_d;
    logic [7:0]       base_y_q, base_y_d;
    logic [COL_W-1:0] base_col_q, base_col_d;
    logic             pix_valid_q, pix_valid_d;
    logic [8:0]       x_draw_q, x_draw_d;
    logic [7:0]       y_draw_q, y_draw_d;
    logic             last_pix;

    assign last_pix = (px_q == PXW'(SPRITE_W - 1)) && (py_q == ROW_W'(SPRITE_H - 1));

    always_comb begin
        state_d     = state_q;
        px_d        = px_q;
        py_d        = py_q;
        base_x_d    = base_x_q;
        base_y_d    = base_y_q;
        base_col_d  = base_col_q;
        pix_valid_d = 1'b0;
        x_draw_d    = x_draw_q;
        y_draw_d    = y_draw_q;

        case (state_q)
            DS_IDLE: begin
                // Snapshot position and pose so later moves cannot tear this sprite.
                if (draw) begin
                    state_d    = DS_RUN;
                    px_d       = '0;
                    py_d       = '0;
                    base_x_d   = x_pos;
                    base_y_d   = y_pos;
                    base_col_d = col_base;
                end
            end
            DS_RUN: begin
                if (!draw) begin
                    state_d = DS_IDLE;
                end else begin
                    pix_valid_d = 1'b1;
                    x_draw_d    = base_x_q + 9'(px_q);
                    y_draw_d    = base_y_q + 8'(py_q);
                    if (last_pix) begin
                        state_d = DS_FLUSH;
                    end else if (px_q == PXW'(SPRITE_W - 1)) begin
                        px_d = '0;
                        py_d = py_q + ROW_W'(1);
                    end else begin
                        px_d = px_q + PXW'(1);
                    end
                end
            end
            DS_FLUSH:    state_d = DS_DONE;
            DS_DONE:     state_d = DS_WAIT_LOW;
            DS_WAIT_LOW: if (!draw) state_d = DS_IDLE;
            default:     state_d = DS_IDLE;
        endcase

        if (abort) begin
            state_d     = DS_IDLE;
            pix_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= DS_IDLE;
            px_q        <= '0;
            py_q        <= '0;
            base_x_q    <= '0;
            base_y_q    <= '0;
            base_col_q  <= '0;
            pix_valid_q <= 1'b0;
            x_draw_q    <= '0;
            y_draw_q    <= '0;
        end else begin
            state_q     <= state_d;
            px_q        <= px_d;
            py_q        <= py_d;
            base_x_q    <= base_x_d;
            base_y_q    <= base_y_d;
            base_col_q  <= base_col_d;
            pix_valid_q <= pix_valid_d;
            x_draw_q    <= x_draw_d;
            y_draw_q    <= y_draw_d;
        end
    end

    assign mem_addr  = (state_q == DS_RUN) ? {py_q, base_col_q + COL_W'(px_q)} : '0;
    assign x_draw    = x_draw_q;
    assign y_draw    = y_draw_q;
    assign colour    = mem_q;
    assign vga_write = pix_valid_q && (mem_q != TRANSPARENT);
    assign draw_done = (state_q == DS_DONE);

endmodule

// File: rtl/char_sprite_engine.sv
// Character sprite engine: command latching, movement, knockback, attack timing
// and walk animation, feeding the sprite draw sequencer.
module char_sprite_engine
    import char_pkg::*;
#(
    parameter int         SPRITE_W    = 16,
    parameter int         SPRITE_H    = 16,
    parameter int         STEP        = 1,
    parameter int         FRAMES      = 2,
    parameter int         ANIM_DIV    = 8,
    parameter int         ATTACK_LEN  = 16,
    parameter int         X_MIN       = 0,
    parameter int         X_MAX       = 303,
    parameter int         Y_MIN       = 0,
    parameter int         Y_MAX       = 223,
    parameter int         X_INIT      = 1,
    parameter int         Y_INIT      = 96,
    parameter logic [5:0] TRANSPARENT = 6'h3F,
    localparam int        COL_W       = $clog2(8 * FRAMES * SPRITE_W),
    localparam int        ROW_W       = $clog2(SPRITE_H),
    localparam int        AW          = ROW_W + COL_W
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          c_attack,
    input  logic          c_up,
    input  logic          c_down,
    input  logic          c_left,
    input  logic          c_right,
    input  logic          init,
    input  logic          reg_action,
    input  logic          apply_action,
    input  logic          draw,
    input  logic [1:0]    collision,
    output logic [AW-1:0] mem_addr,
    input  logic [5:0]    mem_q,
    output logic [8:0]    x_pos,
    output logic [7:0]    y_pos,
    output logic [8:0]    x_draw,
    output logic [7:0]    y_draw,
    output logic [2:0]    direction,
    output logic [2:0]    facing,
    output logic          attacking,
    output logic [5:0]    colour,
    output logic          VGA_write,
    output logic          draw_done
);

    localparam int ACW = (ATTACK_LEN > 1) ? $clog2(ATTACK_LEN) : 1;
    localparam int ANW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int FW  = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    localparam logic signed [11:0] STEP_S  = 12'(STEP);
    localparam logic signed [11:0] X_MIN_S = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] Y_MIN_S = 12'(Y_MIN);
    localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);

    logic [8:0]       x_q, x_d;
    logic [7:0]       y_q, y_d;
    dir_e             facing_q, facing_d;
    dir_e             direction_q, direction_d;
    logic             attacking_q, attacking_d;
    logic [ACW-1:0]   attack_cnt_q, attack_cnt_d;
    logic [ANW-1:0]   anim_cnt_q, anim_cnt_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic signed [11:0] tx, ty;
    logic             walk;
    logic [2:0]       sheet_idx;
    logic [COL_W-1:0] col_base;

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        facing_d     = facing_q;
        direction_d  = direction_q;
        attacking_d  = attacking_q;
        attack_cnt_d = attack_cnt_q;
        anim_cnt_d   = anim_cnt_q;
        frame_d      = frame_q;
        tx           = $signed({3'b000, x_q});
        ty           = $signed({4'b0000, y_q});
        walk         = 1'b0;

        if (init) begin
            x_d          = 9'(X_INIT);
            y_d          = 8'(Y_INIT);
            facing_d     = DIR_DOWN;
            direction_d  = DIR_NONE;
            attacking_d  = 1'b0;
            attack_cnt_d = '0;
            anim_cnt_d   = '0;
            frame_d      = '0;
        end else if (reg_action) begin
            if (c_attack)     direction_d = DIR_ATTACK;
            else if (c_up)    direction_d = DIR_UP;
            else if (c_down)  direction_d = DIR_DOWN;
            else if (c_left)  direction_d = DIR_LEFT;
            else if (c_right) direction_d = DIR_RIGHT;
            else              direction_d = DIR_NONE;
        end else if (apply_action) begin
            // Knockback pushes against the facing and suppresses any walk step.
            if (collision[1]) begin
                case (facing_q)
                    DIR_UP:    ty = ty + STEP_S;
                    DIR_DOWN:  ty = ty - STEP_S;
                    DIR_LEFT:  tx = tx + STEP_S;
                    DIR_RIGHT: tx = tx - STEP_S;
                    default: ;
                endcase
            end

            if (attacking_q) begin
                if (attack_cnt_q == '0) attacking_d = 1'b0;
                else                    attack_cnt_d = attack_cnt_q - ACW'(1);
            end else if (direction_q == DIR_ATTACK) begin
                attacking_d  = 1'b1;
                attack_cnt_d = ACW'(ATTACK_LEN - 1);
            end else if (!collision[1] && is_move(direction_q)) begin
                facing_d = direction_q;
                walk     = !collision[0];
                if (walk) begin
                    case (direction_q)
                        DIR_UP:    ty = ty - STEP_S;
                        DIR_DOWN:  ty = ty + STEP_S;
                        DIR_LEFT:  tx = tx - STEP_S;
                        DIR_RIGHT: tx = tx + STEP_S;
                        default: ;
                    endcase
                end
            end

            x_d = (tx < X_MIN_S) ? 9'(X_MIN) : ((tx > X_MAX_S) ? 9'(X_MAX) : tx[8:0]);
            y_d = (ty < Y_MIN_S) ? 8'(Y_MIN) : ((ty > Y_MAX_S) ? 8'(Y_MAX) : ty[7:0]);

            // Only steps that really moved the character advance the walk cycle.
            if (walk && ((x_d != x_q) || (y_d != y_q))) begin
                if (anim_cnt_q == ANW'(ANIM_DIV - 1)) begin
                    anim_cnt_d = '0;
                    frame_d    = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + FW'(1);
                end else begin
                    anim_cnt_d = anim_cnt_q + ANW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q          <= 9'(X_INIT);
            y_q          <= 8'(Y_INIT);
            facing_q     <= DIR_DOWN;
            direction_q  <= DIR_NONE;
            attacking_q  <= 1'b0;
            attack_cnt_q <= '0;
            anim_cnt_q   <= '0;
            frame_q      <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            facing_q     <= facing_d;
            direction_q  <= direction_d;
            attacking_q  <= attacking_d;
            attack_cnt_q <= attack_cnt_d;
            anim_cnt_q   <= anim_cnt_d;
            frame_q      <= frame_d;
        end
    end

    assign sheet_idx = {attacking_q, facing_idx(facing_q)};
    assign col_base  = COL_W'((int'(sheet_idx) * FRAMES + int'(frame_q)) * SPRITE_W);

    assign x_pos     = x_q;
    assign y_pos     = y_q;
    assign facing    = facing_q;
    assign direction = direction_q;
    assign attacking = attacking_q;

    sprite_draw_seq #(
        .SPRITE_W    (SPRITE_W),
        .SPRITE_H    (SPRITE_H),
        .COL_W       (COL_W),
        .ROW_W       (ROW_W),
        .TRANSPARENT (TRANSPARENT)
    ) u_seq (
        .clock     (clock),
        .resetn    (resetn),
        .draw      (draw),
        .abort     (init),
        .x_pos     (x_q),
        .y_pos     (y_q),
        .col_base  (col_base),
        .mem_addr  (mem_addr),
        .mem_q     (mem_q),
        .x_draw    (x_draw),
        .y_draw    (y_draw),
        .colour    (colour),
        .vga_write (VGA_write),
        .draw_done (draw_done)
    );

endmodule

// File: tb/tb_char_sprite_engine.sv
// Randomised scoreboard bench for char_sprite_engine with a behavioural model
// of movement/attack/animation and a ROM model feeding the draw path.
`timescale 1ns/1ps
module tb_char_sprite_engine;
    import char_pkg::*;

    localparam int SPRITE_W   = 16;
    localparam int SPRITE_H   = 16;
    localparam int STEP       = 1;
    localparam int FRAMES     = 2;
    localparam int ANIM_DIV   = 8;
    localparam int ATTACK_LEN = 16;
    localparam int X_MIN = 0, X_MAX = 303, Y_MIN = 0, Y_MAX = 223;
    localparam int X_INIT = 1, Y_INIT = 96;
    localparam int COL_W = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        c_attack = 0, c_up = 0, c_down = 0, c_left = 0, c_right = 0;
    logic        init = 0, reg_action = 0, apply_action = 0, draw = 0;
    logic [1:0]  collision = 2'b00;
    logic [11:0] mem_addr;
    logic [5:0]  mem_q;
    logic [8:0]  x_pos, x_draw;
    logic [7:0]  y_pos, y_draw;
    logic [2:0]  direction, facing;
    logic        attacking, VGA_write, draw_done;
    logic [5:0]  colour;

    char_sprite_engine dut (
        .clock(clock), .resetn(resetn),
        .c_attack(c_attack), .c_up(c_up), .c_down(c_down), .c_left(c_left), .c_right(c_right),
        .init(init), .reg_action(reg_action), .apply_action(apply_action), .draw(draw),
        .collision(collision), .mem_addr(mem_addr), .mem_q(mem_q),
        .x_pos(x_pos), .y_pos(y_pos), .x_draw(x_draw), .y_draw(y_draw),
        .direction(direction), .facing(facing), .attacking(attacking),
        .colour(colour), .VGA_write(VGA_write), .draw_done(draw_done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    typedef struct { int x; int y; int c; } pix_t;
    pix_t exp_q[$];
    pix_t mon_e;
    int   draw_writes = 0;
    logic [5:0] rom [4096];
    bit   all_transp = 0;

    always @(posedge clock) mem_q <= all_transp ? 6'h3F : rom[mem_addr];

    // Model state: position, facing, latched command, attack ticks left, walk steps taken.
    int m_x, m_y, m_face, m_dir, m_att, m_rem, m_moves;

    always @(negedge clock) begin
        if (VGA_write) begin
            draw_writes++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_pixel actual=(%0d,%0d,%0h) expected=none", x_draw, y_draw, colour);
            end else begin
                mon_e = exp_q.pop_front();
                if (x_draw != mon_e.x || y_draw != mon_e.y || colour != mon_e.c) begin
                    bad++;
                    $display("[TB] FAIL pixel actual=(%0d,%0d,%0h) expected=(%0d,%0d,%0h)",
                             x_draw, y_draw, colour, mon_e.x, mon_e.y, mon_e.c);
                end
            end
        end
    end

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int fidx(input int f);
        case (f)
            4: return 1;
            2: return 2;
            5: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int model_col_base();
        return ((m_att * 4 + fidx(m_face)) * FRAMES + (m_moves / ANIM_DIV) % FRAMES) * SPRITE_W;
    endfunction

    task automatic model_init();
        m_x = X_INIT; m_y = Y_INIT; m_face = 3; m_dir = 0;
        m_att = 0; m_rem = 0; m_moves = 0;
    endtask

    task automatic model_apply(input logic [1:0] col);
        int nx, ny;
        if (col[1]) begin
            case (m_face)
                2: m_y = clampi(m_y + STEP, Y_MIN, Y_MAX);
                3: m_y = clampi(m_y - STEP, Y_MIN, Y_MAX);
                4: m_x = clampi(m_x + STEP, X_MIN, X_MAX);
                5: m_x = clampi(m_x - STEP, X_MIN, X_MAX);
                default: ;
            endcase
        end
        if (m_att != 0) begin
            m_rem--;
            if (m_rem == 0) m_att = 0;
        end else if (m_dir == 1) begin
            m_att = 1;
            m_rem = ATTACK_LEN;
        end else if (!col[1] && m_dir >= 2) begin
            m_face = m_dir;
            if (!col[0]) begin
                nx = m_x; ny = m_y;
                case (m_dir)
                    2: ny = m_y - STEP;
                    3: ny = m_y + STEP;
                    4: nx = m_x - STEP;
                    default: nx = m_x + STEP;
                endcase
                nx = clampi(nx, X_MIN, X_MAX);
                ny = clampi(ny, Y_MIN, Y_MAX);
                if (nx != m_x || ny != m_y) m_moves++;
                m_x = nx; m_y = ny;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_output();
        check("x_pos", x_pos, m_x);
        check("y_pos", y_pos, m_y);
        check("facing", facing, m_face);
        check("direction", direction, m_dir);
        check("attacking", attacking, m_att);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reg(input bit a, input bit u, input bit d, input bit l, input bit r);
        c_attack = a; c_up = u; c_down = d; c_left = l; c_right = r;
        reg_action = 1; step(1); reg_action = 0;
        if (a) m_dir = 1; else if (u) m_dir = 2; else if (d) m_dir = 3;
        else if (l) m_dir = 4; else if (r) m_dir = 5; else m_dir = 0;
    endtask

    task automatic do_apply(input logic [1:0] col);
        collision = col; apply_action = 1; step(1); apply_action = 0; collision = 2'b00;
        model_apply(col);
    endtask

    task automatic do_init();
        init = 1; step(1); init = 0;
        model_init();
    endtask

    task automatic push_expected(output int exp_n);
        int cb, addr;
        logic [5:0] c;
        cb = model_col_base();
        exp_n = 0;
        for (int py = 0; py < SPRITE_H; py++) begin
            for (int px = 0; px < SPRITE_W; px++) begin
                addr = (py << COL_W) | (cb + px);
                c = all_transp ? 6'h3F : rom[addr];
                if (c != 6'h3F) begin
                    exp_q.push_back('{m_x + px, m_y + py, int'(c)});
                    exp_n++;
                end
            end
        end
    endtask

    task automatic run_draw(input bit mid_move);
        int exp_n, cyc;
        bit seen;
        push_expected(exp_n);
        draw_writes = 0;
        draw = 1;
        step(1);
        cyc = 1;
        seen = 0;
        while (!seen && cyc < 400) begin
            if (mid_move && cyc == 50) begin
                apply_action = 1;
                model_apply(2'b00);
            end
            if (cyc == 51) apply_action = 0;
            step(1);
            cyc++;
            if (draw_done) seen = 1;
        end
        apply_action = 0;
        check("draw_done_cycle", seen ? cyc : -1, 258);
        step(1);
        check("draw_done_pulse", draw_done, 0);
        draw = 0;
        step(2);
        check("draw_pixels", draw_writes, exp_n);
        check("draw_queue_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_abort(input bit by_reset);
        int exp_n;
        bit seen;
        push_expected(exp_n);
        draw = 1;
        step(101);
        draw = 0;
        if (by_reset) begin
            resetn = 0; step(2); resetn = 1;
            model_init();
        end else begin
            do_init();
        end
        exp_q.delete();
        seen = 0;
        repeat (300) begin
            step(1);
            if (draw_done || VGA_write) seen = 1;
        end
        check(by_reset ? "reset_abort_quiet" : "init_abort_quiet", seen, 0);
        check("abort_fsm_idle", int'(dut.u_seq.state_q), int'(DS_IDLE));
        check_output();
    endtask

    task automatic apply_stimulus(input int n);
        int op, cr;
        logic [1:0] col;
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, 99);
            if (op < 35) begin
                do_reg($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            end else if (op < 94) begin
                cr = $urandom_range(0, 9);
                col = (cr == 0) ? 2'b01 : (cr == 1) ? 2'b10 : (cr == 2) ? 2'b11 : 2'b00;
                do_apply(col);
            end else if (op < 97) begin
                do_init();
            end else begin
                run_draw(0);
            end
            check_output();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 6'($urandom_range(0, 63));
        model_init();

        step(2);
        check("rst_x_draw", x_draw, 0);
        check("rst_y_draw", y_draw, 0);
        check("rst_vga_write", VGA_write, 0);
        check("rst_draw_done", draw_done, 0);
        check("rst_mem_addr", mem_addr, 0);
        check_output();
        resetn = 1;
        step(1);

        run_draw(0);

        do_reg(0, 0, 0, 1, 0);
        repeat (4) do_apply(2'b00);
        check("left_clamp_x", x_pos, 0);
        check("left_clamp_facing", facing, 4);
        check_output();
        run_draw(0);

        do_init();
        do_reg(0, 0, 0, 0, 1);
        repeat (8) do_apply(2'b00);
        check("walk8_x", x_pos, 9);
        check_output();
        run_draw(0);
        repeat (8) do_apply(2'b00);
        check_output();
        run_draw(0);

        do_init();
        do_reg(1, 0, 0, 0, 0);
        do_apply(2'b00);
        check("attack_start", attacking, 1);
        do_reg(0, 1, 0, 0, 0);
        run_draw(0);
        for (int t = 1; t <= 16; t++) begin
            do_apply(2'b00);
            check("attack_y_hold", y_pos, 96);
            check("attack_flag", attacking, (t < 16) ? 1 : 0);
        end
        check_output();

        do_init();
        do_apply(2'b11);
        check("knockback_y", y_pos, 95);
        check_output();
        all_transp = 1;
        run_draw(0);
        all_transp = 0;

        do_reg(0, 0, 1, 0, 0);
        run_draw(1);
        check_output();

        run_abort(0);
        run_abort(1);

        apply_stimulus(300);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
